// File: rtl/cic_pkg.sv
// cic_pkg: shared constants and width helpers for the CIC interpolator.
// Width math is evaluated at elaboration time only.
package cic_pkg;

  localparam int MAX_N = 6;
  localparam int MAX_R = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cic_wfull(
    input int win,
    input int n,
    input int r,
    input int m
  );
    return win + n * clog2(r * m);
  endfunction

  // Bit offset of comb segment k in the packed comb bus;
  // segment k is win+k bits wide.
  function automatic int cic_off(
    input int win,
    input int k
  );
    return k * win + (k * (k - 1)) / 2;
  endfunction

endpackage

// File: rtl/cic_comb_m.sv
// cic_comb_m: one valid-qualified comb stage, y = x - x[n-M].
// Output grows by one bit; delay line moves only on valid.
module cic_comb_m
  import cic_pkg::*;
#(
  parameter int W = 16,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  input  logic         vld_in,
  output logic [W:0]   y,
  output logic         vld_out
);

  logic [W-1:0] dly [M];

  // difference against the M-deep history, advance on valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < M; i++) dly[i] <= '0;
      y       <= '0;
      vld_out <= 1'b0;
    end else begin
      vld_out <= vld_in;
      if (vld_in) begin
        y      <= {x[W-1], x} - {dly[M-1][W-1], dly[M-1]};
        dly[0] <= x;
        for (int i = 1; i < M; i++) dly[i] <= dly[i-1];
      end
    end
  end

endmodule

// File: rtl/cic_interp_param.sv
// cic_interp_param: N combs, xR zero-stuffer, N integrators.
// Macro CIC_ROUND_EN: round/saturate output reduction, +1 stage.
module cic_interp_param
  import cic_pkg::*;
#(
  parameter int WIN  = 16,
  parameter int N    = 3,
  parameter int R    = 4,
  parameter int M    = 1,
  parameter int WOUT = 22
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WIN-1:0]  i_data,
  input  logic            val_in,
  output logic            in_ready,
  output logic [WOUT-1:0] o_data,
  output logic            val_out,
  output logic            overrun
);

  localparam int WFULL = cic_wfull(WIN, N, R, M);
  localparam int WC    = WIN + N;
  localparam int WX    = (WFULL > WC) ? WFULL : WC;
  localparam int CW    = (clog2(R) > 0) ? clog2(R) : 1;
  localparam int TOT   = cic_off(WIN, N + 1);
  localparam logic [CW-1:0] RLD = CW'(R - 1);

  logic [CW-1:0] gap;
  logic          take;

  assign in_ready = (gap == '0);
  assign take     = val_in & in_ready;

  // input spacing counter and sticky drop flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap     <= '0;
      overrun <= 1'b0;
    end else begin
      if (take)
        gap <= RLD;
      else if (gap != '0)
        gap <= gap - CW'(1);
      if (val_in && !in_ready)
        overrun <= 1'b1;
    end
  end

  logic [TOT-1:0] cbus;
  logic [N:0]     cv;

  assign cbus[WIN-1:0] = i_data;
  assign cv[0]         = take;

  for (genvar k = 0; k < N; k++) begin : g_comb
    cic_comb_m #(
      .W(WIN + k),
      .M(M)
    ) u_comb (
      .clk     (clk),
      .rst     (rst),
      .x       (cbus[cic_off(WIN, k) +: WIN + k]),
      .vld_in  (cv[k]),
      .y       (cbus[cic_off(WIN, k + 1) +: WIN + k + 1]),
      .vld_out (cv[k+1])
    );
  end

  logic [WX-1:0]    ext;
  logic [WFULL-1:0] ex_in;

  assign ext   = WX'($signed(cbus[cic_off(WIN, N) +: WC]));
  assign ex_in = ext[WFULL-1:0];

  logic [WFULL-1:0] ex_d;
  logic             ex_v;
  logic [CW-1:0]    ex_cnt;

  // zero-stuffer: sample, then R-1 zeros on back-to-back cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_d   <= '0;
      ex_v   <= 1'b0;
      ex_cnt <= '0;
    end else if (cv[N]) begin
      ex_d   <= ex_in;
      ex_v   <= 1'b1;
      ex_cnt <= RLD;
    end else if (ex_cnt != '0) begin
      ex_d   <= '0;
      ex_v   <= 1'b1;
      ex_cnt <= ex_cnt - CW'(1);
    end else begin
      ex_d   <= '0;
      ex_v   <= 1'b0;
    end
  end

  logic [N-1:0][WFULL-1:0] acc;
  logic [N-1:0]            iv;

  // integrator chain, modulo-2^WFULL accumulation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      iv  <= '0;
    end else begin
      iv[0] <= ex_v;
      if (ex_v)
        acc[0] <= acc[0] + ex_d;
      for (int k = 1; k < N; k++) begin
        iv[k] <= iv[k-1];
        if (iv[k-1])
          acc[k] <= acc[k] + acc[k-1];
      end
    end
  end

  logic [WOUT-1:0] trunc;

  assign trunc = acc[N-1][WFULL-1 -: WOUT];

`ifdef CIC_ROUND_EN
  if (WOUT < WFULL) begin : g_rnd
    localparam int D = WFULL - WOUT;
    localparam logic [WOUT-1:0] MAXP =
      {1'b0, {(WOUT-1){1'b1}}};

    logic [WOUT-1:0] o_r;
    logic            v_r;
    logic            half;

    assign half = acc[N-1][D-1];

    // round half up; clamp at max positive on overflow
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        o_r <= '0;
        v_r <= 1'b0;
      end else begin
        v_r <= iv[N-1];
        if (iv[N-1])
          o_r <= (half && trunc == MAXP) ?
                 MAXP : trunc + WOUT'(half);
      end
    end

    assign o_data  = o_r;
    assign val_out = v_r;
  end else begin : g_pass
    assign o_data  = trunc;
    assign val_out = iv[N-1];
  end
`else
  assign o_data  = trunc;
  assign val_out = iv[N-1];
`endif

endmodule
